mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external 32-bit memory bus between the IF stage (instruction fetch) and the MEM stage (loads and stores).
- Arbitrates between the two requesters and sequences each bus transaction through a small FSM.
- Generates byte strobes for stores, and aligns plus sign- or zero-extends load data per mem_sz/mem_sx.
- Its stall outputs feed the pipeline's stall/bubble logic.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants while a fetch is pending before fetch is forced to win once.
- TIMEOUT, 64: bus watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch address; word aligned, bits [1:0] ignored
- if_ack  out  1  one-cycle pulse; fetch complete
- if_rdata  out  32  fetched instruction; valid while if_ack=1
- d_req  in  1  data request; held until d_ack
- d_addr  in  32  data address
- d_we  in  1  1 = store, 0 = load
- d_sz  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- d_sx  in  1  sign-extend loads
- d_wdata  in  32  store data, right-justified
- d_ack  out  1  one-cycle pulse; data access complete
- d_err  out  1  valid with d_ack; misaligned/reserved size (or timeout)
- d_rdata  out  32  extended load data; valid with d_ack
- if_stall  out  1  if_req=1 and if_ack=0
- d_stall  out  1  d_req=1 and d_ack=0
- bus_req  out  1  bus request; held until bus_ack
- bus_addr  out  32  word address, bits [1:0] = 0
- bus_we  out  1  write enable
- bus_wstrb  out  4  byte lane enables
- bus_wdata  out  32  lane-replicated write data
- bus_ack  in  1  one-cycle completion pulse
- bus_rdata  in  32  read data; valid with bus_ack

Behaviour:
- Reset: all outputs 0, FSM = IDLE, starvation counter = 0.
- States: IDLE, IBUS, DBUS, RESP. All outputs are registered.
- IDLE arbitration:
  - d_req beats if_req, unless the starvation counter equals STARVE_LIMIT and if_req=1; then fetch wins and the counter clears.
  - The counter increments on each data grant made while if_req=1, saturates at STARVE_LIMIT, and clears on any fetch grant.
- IDLE transitions:
  - Winner fetch → IBUS.
  - Winner data, legal → DBUS.
  - Winner data, illegal → RESP with d_err=1, no bus cycle.
  - Illegal means d_sz=3, or half with d_addr[0]=1, or word with d_addr[1:0]≠0.
  - On entering IBUS/DBUS, bus_req, bus_addr, bus_we, bus_wstrb and bus_wdata are registered at the same edge.
- Store lanes:
  - Byte: wstrb = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'b1111.
  - Loads: wstrb = 0.
- IBUS/DBUS: bus_req stays 1 and the bus fields stay stable until bus_ack. On bus_ack the FSM goes to RESP and bus_req drops at that edge.
- RESP lasts exactly one cycle:
  - The selected ack is 1 and rdata is valid.
  - Loads: select the lane by addr[1:0], then zero- or sign-extend per d_sx; stores return d_rdata=0.
  - Next state is IDLE.
- Latency, with the request seen in IDLE at cycle 0 and the bus acking in cycle k≥1:
  - bus_req is high in cycles 1..k.
  - The ack is in cycle k+1.
  - The next grant is possible at cycle k+2.
  - Misaligned access: d_ack+d_err in cycle 1.
- Requester rule: deassert req the cycle after ack. Grants are evaluated only in IDLE.
- Requests arriving in a non-IDLE state wait. A simultaneous if_req and d_req is resolved by the priority rule above.
- bus_ack seen outside IBUS/DBUS is ignored.
- Reset mid-transaction: return to IDLE immediately, bus_req=0, and no ack is issued.

Optional Feature:
- Macro ARB_TIMEOUT_EN, when defined:
  - A watchdog counts cycles in IBUS/DBUS.
  - If it reaches TIMEOUT without bus_ack, bus_req drops and the FSM goes to RESP.
  - The pending ack is asserted with rdata=0. For data, d_err=1. Fetch has no error port and returns 0.
- When undefined: no counter, and a transaction waits for bus_ack forever.

Test Plan:
- Word load, d_addr=0x100, bus acks in cycle 3 with 0xDEADBEEF → bus_req high cycles 1-3, d_ack cycle 4, d_rdata=0xDEADBEEF, d_err=0.
- Byte load, d_addr=0x103, d_sx=1, bus_rdata=0x80FFFFFF → d_rdata=0xFFFFFF80; repeat with d_sx=0 → 0x00000080.
- Half store, d_addr=0x202, d_wdata=0x1234ABCD → bus_wstrb=4'b1100, bus_wdata=0xABCDABCD, bus_we=1.
- Misaligned word, d_addr=0x101 → no bus_req; d_ack=1 and d_err=1 in cycle 1.
- if_req held with d_req back-to-back, STARVE_LIMIT=4 → exactly 4 data grants, then 1 fetch grant; if_rdata matches bus_rdata.
- Reset asserted during DBUS → bus_req=0 asynchronously, no d_ack; after release, a new load completes normally. With ARB_TIMEOUT_EN and TIMEOUT=64, no bus_ack → d_ack+d_err at cycle 65.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit memory bus between instruction fetch and data access.
// Define ARB_TIMEOUT_EN to add a bus watchdog that aborts transactions after TIMEOUT cycles.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [1:0]  d_sz,
  input  logic        d_sx,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        if_stall,
  output logic        d_stall,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [1:0]    ld_off;
  logic [1:0]    ld_sz;
  logic          ld_sx;
  logic          ld_store;

  logic          d_illegal;
  logic          fetch_wins;
  logic [3:0]    store_strb;
  logic [31:0]   store_wdata;
  logic          timeout_hit;
  logic          unused_bits;

  assign unused_bits = ^if_addr[1:0];
  assign if_stall    = if_req & ~if_ack;
  assign d_stall     = d_req & ~d_ack;

  // Fetch only beats a pending data request once data has won STARVE_LIMIT times in a row.
  assign fetch_wins = if_req & (~d_req | (starve_cnt == STARVE_MAX));

  always_comb begin
    d_illegal   = 1'b0;
    store_strb  = 4'b1111;
    store_wdata = d_wdata;
    case (d_sz)
      2'd0: begin
        store_strb  = 4'b0001 << d_addr[1:0];
        store_wdata = {4{d_wdata[7:0]}};
      end
      2'd1: begin
        d_illegal   = d_addr[0];
        store_strb  = d_addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{d_wdata[15:0]}};
      end
      2'd2:    d_illegal = (d_addr[1:0] != 2'b00);
      default: d_illegal = 1'b1;
    endcase
  end

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] sz, input logic sx);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (sz)
      2'd0:    return {{24{sx & lane[7]}}, lane[7:0]};
      2'd1:    return {{16{sx & lane[15]}}, lane[15:0]};
      default: return word;
    endcase
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WW-1:0] wdog;

  assign timeout_hit = (wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if ((state == IBUS || state == DBUS) && !bus_ack) begin
      wdog <= wdog + WW'(1);
    end else begin
      wdog <= '0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ld_off     <= '0;
      ld_sz      <= '0;
      ld_sx      <= 1'b0;
      ld_store   <= 1'b0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      bus_req    <= 1'b0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_wstrb  <= '0;
      bus_wdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_wins) begin
            state      <= IBUS;
            starve_cnt <= '0;
            bus_req    <= 1'b1;
            bus_addr   <= {if_addr[31:2], 2'b00};
            bus_we     <= 1'b0;
            bus_wstrb  <= 4'b0000;
            bus_wdata  <= '0;
          end else if (d_req) begin
            if (if_req && starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
            ld_off   <= d_addr[1:0];
            ld_sz    <= d_sz;
            ld_sx    <= d_sx;
            ld_store <= d_we;
            if (d_illegal) begin
              // Rejected without touching the bus.
              state   <= RESP;
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              state     <= DBUS;
              bus_req   <= 1'b1;
              bus_addr  <= {d_addr[31:2], 2'b00};
              bus_we    <= d_we;
              bus_wstrb <= d_we ? store_strb : 4'b0000;
              bus_wdata <= d_we ? store_wdata : 32'd0;
            end
          end
        end
        IBUS: begin
          if (bus_ack) begin
            state    <= RESP;
            bus_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= bus_rdata;
          end else if (timeout_hit) begin
            state    <= RESP;
            bus_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= '0;
          end
        end
        DBUS: begin
          if (bus_ack) begin
            state   <= RESP;
            bus_req <= 1'b0;
            d_ack   <= 1'b1;
            d_rdata <= ld_store ? 32'd0 : extend_load(bus_rdata, ld_off, ld_sz, ld_sx);
          end else if (timeout_hit) begin
            state   <= RESP;
            bus_req <= 1'b0;
            d_ack   <= 1'b1;
            d_err   <= 1'b1;
            d_rdata <= '0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed test-plan steps, then randomized
// fetch/data traffic checked against a behavioural model of lanes, extension and arbitration.
module tb_mem_bus_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_we;
  logic [1:0]  d_sz;
  logic        d_sx;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        if_stall;
  logic        d_stall;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int tests_run    = 0;
  int tests_failed = 0;
  int starve_m     = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_sz(d_sz), .d_sx(d_sx),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .if_stall(if_stall), .d_stall(d_stall),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_access(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [31:0] a, input logic [1:0] sz);
    int m;
    if (sz == 2'd0)      m = 1 << (a % 4);
    else if (sz == 2'd1) m = 3 << (a % 4);
    else                 m = 15;
    return 4'(m);
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] w, input logic [1:0] sz);
    if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sx);
    int          nbits;
    logic [31:0] mask;
    logic [31:0] v;
    if (sz == 2'd2) return rd;
    nbits = 8 << sz;
    mask  = (32'd1 << nbits) - 32'd1;
    v     = (rd >> (8 * (a % 4))) & mask;
    if (sx && ((v >> (nbits - 1)) & 32'd1) != 0) v = v | ~mask;
    return v;
  endfunction

  // Data keeps priority unless fetch has already waited through LIMIT consecutive data grants.
  function automatic bit fetch_predicted();
    if (!d_req) return 1'b1;
    if (if_req && starve_m >= LIMIT) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_d(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic sx, input logic [31:0] w);
    d_req   = 1'b1;
    d_addr  = a;
    d_we    = we;
    d_sz    = sz;
    d_sx    = sx;
    d_wdata = w;
  endtask

  // Called in an IDLE cycle with requests applied; returns in the cycle carrying the ack.
  task automatic service(input bit fetch, input int lat, input logic [31:0] rd);
    logic [31:0] ea;
    logic [31:0] ld_exp;
    logic        store;
    bit          ok;
    if (fetch) starve_m = 0;
    else if (if_req && starve_m < LIMIT) starve_m++;
    ea     = (fetch ? if_addr : d_addr) & ~32'h3;
    ok     = fetch || legal_access(d_addr, d_sz);
    store  = !fetch && d_we;
    ld_exp = store ? 32'd0 : load_value(rd, d_addr, d_sz, d_sx);
    tick();
    if (!ok) begin
      chk("bad_d_ack", d_ack, 1);
      chk("bad_d_err", d_err, 1);
      chk("bad_no_bus", bus_req, 0);
      chk("bad_if_ack", if_ack, 0);
      chk("bad_d_stall", d_stall, 0);
      return;
    end
    for (int c = 1; c <= lat; c++) begin
      chk("busy_req", bus_req, 1);
      chk("busy_addr", bus_addr, ea);
      chk("busy_acks", {if_ack, d_ack}, 0);
      chk("busy_stall", fetch ? if_stall : d_stall, 1);
      if (c == 1) begin
        chk("bus_we", bus_we, store);
        chk("bus_wstrb", bus_wstrb, store ? lane_mask(d_addr, d_sz) : 4'h0);
        if (store) chk("bus_wdata", bus_wdata, lane_data(d_wdata, d_sz));
      end
      if (c == lat) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
      end
      tick();
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
    chk("resp_bus_req", bus_req, 0);
    if (fetch) begin
      chk("if_ack", if_ack, 1);
      chk("if_rdata", if_rdata, rd);
      chk("if_other_ack", d_ack, 0);
      chk("if_stall_resp", if_stall, 0);
    end else begin
      chk("d_ack", d_ack, 1);
      chk("d_err", d_err, 0);
      chk("d_rdata", d_rdata, ld_exp);
      chk("d_other_ack", if_ack, 0);
      chk("d_stall_resp", d_stall, 0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    bit          f;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_addr = '0; d_we = 1'b0;
    d_sz = '0; d_sx = 1'b0; d_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_acks", {if_ack, d_ack, d_err}, 0);
    chk("rst_bus_fields", bus_addr | bus_wdata | {28'd0, bus_wstrb} | {31'd0, bus_we}, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    chk("rst_stalls", {if_stall, d_stall}, 0);
    rst = 1'b0;
    tick();

    // Starvation: fetch held while data is requested back-to-back.
    if_req  = 1'b1;
    if_addr = 32'h0000_4000;
    set_d(32'h300, 1'b0, 2'd2, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      service(i == 4, 1 + (i % 3), $urandom);
      if (i < 4) d_addr = 32'h300 + 32'(4 * (i + 1));
      else if_req = 1'b0;
      tick();
    end
    service(1'b0, 1, 32'h1111_2222);
    d_req = 1'b0;
    tick();

    set_d(32'h100, 1'b0, 2'd2, 1'b0, 32'd0);
    service(1'b0, 3, 32'hDEAD_BEEF);
    chk("tp_word_load", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick();

    set_d(32'h103, 1'b0, 2'd0, 1'b1, 32'd0);
    service(1'b0, 1, 32'h80FF_FFFF);
    chk("tp_byte_sx", d_rdata, 32'hFFFF_FF80);
    d_req = 1'b0;
    tick();
    set_d(32'h103, 1'b0, 2'd0, 1'b0, 32'd0);
    service(1'b0, 2, 32'h80FF_FFFF);
    chk("tp_byte_zx", d_rdata, 32'h0000_0080);
    d_req = 1'b0;
    tick();

    set_d(32'h202, 1'b1, 2'd1, 1'b0, 32'h1234_ABCD);
    tick();
    chk("tp_half_strb", bus_wstrb, 4'b1100);
    chk("tp_half_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("tp_half_we", bus_we, 1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("tp_half_ack", d_ack, 1);
    chk("tp_half_rdata", d_rdata, 0);
    d_req = 1'b0;
    tick();

    set_d(32'h101, 1'b0, 2'd2, 1'b0, 32'd0);
    service(1'b0, 1, 32'd0);
    d_req = 1'b0;
    tick();

    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("stray_ack_bus_req", bus_req, 0);
    chk("stray_ack_acks", {if_ack, d_ack}, 0);

    // Reset while the data access is on the bus.
    set_d(32'h500, 1'b0, 2'd2, 1'b0, 32'd0);
    tick();
    chk("mid_rst_busy", bus_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bus_req", bus_req, 0);
    chk("mid_rst_ack", d_ack, 0);
    starve_m = 0;
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ack", {if_ack, d_ack}, 0);
    set_d(32'h504, 1'b0, 2'd1, 1'b1, 32'd0);
    service(1'b0, 2, 32'h0000_8001);
    chk("post_rst_load", d_rdata, 32'hFFFF_8001);
    d_req = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    set_d(32'h600, 1'b0, 2'd2, 1'b0, 32'd0);
    tick();
    for (int c = 1; c <= TMO; c++) begin
      if (c == 1 || c == TMO) begin
        chk("tmo_busy", bus_req, 1);
        chk("tmo_no_ack", d_ack, 0);
      end
      tick();
    end
    chk("tmo_ack", d_ack, 1);
    chk("tmo_err", d_err, 1);
    chk("tmo_rdata", d_rdata, 0);
    chk("tmo_bus_req", bus_req, 0);
    d_req = 1'b0;
    tick();
`endif

    // Random mixed traffic; the loser of an arbitration keeps its request held.
    for (int it = 0; it < 60; it++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (!d_req && (!if_req || $urandom_range(0, 2) != 0)) begin
        r  = $urandom_range(0, 9);
        sz = (r == 9) ? 2'd3 : 2'(r % 3);
        a  = $urandom;
        if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
        set_d(a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom);
      end
      f = fetch_predicted();
      service(f, $urandom_range(1, 4), $urandom);
      if (f) if_req = 1'b0;
      else d_req = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
